// File: rtl/mac_tile_reconfig_if.sv
// rtl/mac_tile_reconfig_if.sv - tile-to-tile datapath bundle for mac_tile_reconfig
interface mac_tile_reconfig_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
);
  logic [bw-1:0]      in_w;
  logic [bw-1:0]      out_e;
  logic [psum_bw-1:0] in_n;
  logic [psum_bw-1:0] out_s;
  logic [3:0]         inst_w;
  logic [3:0]         inst_e;
  logic               flush_in;
  logic               flush_out;

  modport master (
    output in_w, in_n, inst_w, flush_in,
    input  out_e, out_s, inst_e, flush_out
  );

  modport slave (
    input  in_w, in_n, inst_w, flush_in,
    output out_e, out_s, inst_e, flush_out
  );
endinterface

// File: rtl/mac_tile_reconfig.sv
// rtl/mac_tile_reconfig.sv - reconfigurable WS/OS MAC tile with SIMD lanes and daisy-chained flush
module mac_tile_reconfig #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mac_tile_reconfig_if.slave   tile
);
  localparam int hw = bw / 2;

  typedef enum logic {RUN = 1'b0, FWD = 1'b1} fsm_t;

  fsm_t               state_q, state_n;
  logic [bw-1:0]      a_q, b_q;
  logic [psum_bw-1:0] c_q, acc, out_s_q, prod;
  logic [3:0]         inst_q;
  logic               flush_q, load_ready, exec_q, mode_q, simd_q;
  logic               os, mode_chg, os_exec, os_dump, os_fwd;

  // Activation is zero-extended, weight sign-extended; psum_bw >= 2*bw+2 keeps the wrap exact.
  function automatic logic [psum_bw-1:0] mul(input logic [bw-1:0] a, input logic [bw-1:0] w,
                                             input logic simd);
    logic [psum_bw-1:0] r;
    if (simd)
      r = ({{(psum_bw-hw){1'b0}}, a[bw-1:hw]} * {{(psum_bw-hw){w[bw-1]}}, w[bw-1:hw]})
        + ({{(psum_bw-hw){1'b0}}, a[hw-1:0]}  * {{(psum_bw-hw){w[hw-1]}}, w[hw-1:0]});
    else
      r = {{(psum_bw-bw){1'b0}}, a} * {{(psum_bw-bw){w[bw-1]}}, w};
    return r;
  endfunction

  assign prod     = mul(a_q, b_q, simd_q);
  assign os       = tile.inst_w[2];
  assign mode_chg = (os != mode_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (mode_chg) begin
      state_n = RUN;
    end else if (os) begin
      case (state_q)
        RUN:     if (tile.flush_in)  state_n = FWD;
        FWD:     if (!tile.flush_in) state_n = RUN;
        default: state_n = RUN;
      endcase
    end
  end

  always_comb begin
    os_exec = os && (state_q == RUN) && !tile.flush_in && tile.inst_w[1];
    os_dump = os && (state_q == RUN) && tile.flush_in;
    os_fwd  = os && (state_q == FWD) && tile.flush_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      acc        <= '0;
      out_s_q    <= '0;
      inst_q     <= '0;
      flush_q    <= 1'b0;
      load_ready <= 1'b1;
      exec_q     <= 1'b0;
      mode_q     <= 1'b0;
      simd_q     <= 1'b0;
    end else begin
      mode_q  <= os;
      simd_q  <= tile.inst_w[3];
      flush_q <= tile.flush_in;
      exec_q  <= os_exec;
      inst_q  <= os ? tile.inst_w : {tile.inst_w[3:1], tile.inst_w[0] & ~load_ready};

      if (!os) begin
        if (tile.inst_w[0] || tile.inst_w[1]) a_q <= tile.in_w;
        if (tile.inst_w[0] && load_ready)     b_q <= tile.in_w;
        if (tile.inst_w[1])                   c_q <= tile.in_n;
      end else if (os_exec) begin
        a_q <= tile.in_w;
        b_q <= tile.in_n[bw-1:0];
      end

      // Pending product is folded into the dumped sum so no MAC is lost on flush.
      if (os) begin
        if (os_dump)     out_s_q <= acc + (exec_q ? prod : '0);
        else if (os_fwd) out_s_q <= tile.in_n;
        else             out_s_q <= {{(psum_bw-bw){1'b0}}, b_q};
      end

      if (mode_chg) begin
        load_ready <= 1'b1;
      end else if (!os) begin
        if (tile.inst_w[0] && load_ready)       load_ready <= 1'b0;
        else if (inst_q[1] && !tile.inst_w[1])  load_ready <= 1'b1;
      end

      if (mode_chg || os_dump)                acc <= '0;
      else if (os && exec_q && !tile.flush_in) acc <= acc + prod;
    end
  end

  assign tile.out_s     = mode_q ? out_s_q : (c_q + prod);
  assign tile.out_e     = a_q;
  assign tile.inst_e    = inst_q;
  assign tile.flush_out = flush_q;
endmodule

// File: tb/tb_mac_tile_reconfig.sv
// tb/tb_mac_tile_reconfig.sv - self-checking bench for mac_tile_reconfig
module tb_mac_tile_reconfig;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_tile_reconfig_if #(.bw(4), .psum_bw(16)) bus ();
  mac_tile_reconfig #(.bw(4), .psum_bw(16)) dut (.clk(clk), .reset(reset), .tile(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  w;
    logic [3:0]  a;
    logic [15:0] c;
    logic        simd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] inst, input logic [3:0] a, input logic [15:0] n,
                       input logic f);
    bus.inst_w   = inst;
    bus.in_w     = a;
    bus.in_n     = n;
    bus.flush_in = f;
  endtask

  // Exec, drop exec (re-arm), then load the kernel value w.
  task automatic ws_load(input logic [3:0] w, input logic simd);
    drive({simd, 3'b010}, 4'd0, 16'd0, 1'b0); tick();
    drive({simd, 3'b000}, 4'd0, 16'd0, 1'b0); tick();
    drive({simd, 3'b001}, w, 16'd0, 1'b0);    tick();
  endtask

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic int ref_p(input int a, input int w, input bit simd);
    if (simd) return (a / 4) * sx(w / 4, 2) + (a % 4) * sx(w % 4, 2);
    return a * sx(w, 4);
  endfunction

  initial begin
    int sum;
    int k;
    logic [3:0] ra, rw;
    logic [15:0] rc;
    bit rs;

    tbl[0] = '{4'd3,  4'd5,  16'd10,     1'b0, 16'd25};
    tbl[1] = '{4'd14, 4'd7,  16'd0,      1'b0, 16'hFFF2};
    tbl[2] = '{4'd7,  4'd11, 16'd5,      1'b1, 16'd4};
    tbl[3] = '{4'd1,  4'd1,  16'h7FFF,   1'b0, 16'h8000};
    tbl[4] = '{4'd8,  4'd15, 16'd0,      1'b0, 16'hFF88};
    tbl[5] = '{4'd7,  4'd15, 16'hFFFF,   1'b1, 16'hFFFF};

    drive(4'd0, 4'd0, 16'd0, 1'b0);
    reset = 1'b1;
    #3;
    chk("reset_out_s", bus.out_s, 16'd0);
    chk("reset_out_e", {12'd0, bus.out_e}, 16'd0);
    chk("reset_inst_e", {12'd0, bus.inst_e}, 16'd0);
    chk("reset_flush_out", {15'd0, bus.flush_out}, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // WS kernel load: first value captured, second passes east
    drive(4'b0001, 4'd3, 16'd0, 1'b0); tick();
    chk("ws_load_out_e0", {12'd0, bus.out_e}, 16'd3);
    chk("ws_load_inst_e0", {15'd0, bus.inst_e[0]}, 16'd0);
    drive(4'b0001, 4'd5, 16'd0, 1'b0); tick();
    chk("ws_load_out_e1", {12'd0, bus.out_e}, 16'd5);
    chk("ws_load_inst_e1", {15'd0, bus.inst_e[0]}, 16'd1);
    drive(4'b0010, 4'd5, 16'd10, 1'b0); tick();
    chk("ws_exec_first_kernel", bus.out_s, 16'd25);
    drive(4'b0000, 4'd0, 16'd0, 1'b0); tick();
    drive(4'b0001, 4'd6, 16'd0, 1'b0); tick();
    drive(4'b0010, 4'd1, 16'd0, 1'b0); tick();
    chk("ws_rearm", bus.out_s, 16'd6);

    foreach (tbl[i]) begin
      ws_load(tbl[i].w, tbl[i].simd);
      drive({tbl[i].simd, 3'b010}, tbl[i].a, tbl[i].c, 1'b0); tick();
      chk($sformatf("ws_tbl%0d", i), bus.out_s, tbl[i].exp);
      chk($sformatf("ws_tbl%0d_out_e", i), {12'd0, bus.out_e}, {12'd0, tbl[i].a});
    end

    for (int i = 0; i < 20; i++) begin
      rw = 4'($urandom); ra = 4'($urandom); rc = 16'($urandom); rs = 1'($urandom);
      ws_load(rw, rs);
      drive({rs, 3'b010}, ra, rc, 1'b0); tick();
      chk($sformatf("ws_rand%0d", i), bus.out_s, 16'(int'(rc) + ref_p(ra, rw, rs)));
    end

    // OS accumulate then flush; execute during the first flush cycle must be ignored
    drive(4'b0110, 4'd2, 16'd3, 1'b0); tick();
    drive(4'b0110, 4'd4, 16'hF, 1'b0); tick();
    drive(4'b0110, 4'd1, 16'd5, 1'b0); tick();
    drive(4'b0110, 4'd3, 16'hA, 1'b1); tick();
    chk("os_flush_sum", bus.out_s, 16'd7);
    chk("os_flush_out1", {15'd0, bus.flush_out}, 16'd1);
    drive(4'b0100, 4'd0, 16'd100, 1'b1); tick();
    chk("os_fwd_100", bus.out_s, 16'd100);
    drive(4'b0100, 4'd0, 16'd200, 1'b1); tick();
    chk("os_fwd_200", bus.out_s, 16'd200);
    drive(4'b0100, 4'd0, 16'd0, 1'b0); tick();
    chk("os_flush_out0", {15'd0, bus.flush_out}, 16'd0);
    chk("os_weight_south", bus.out_s, 16'd5);
    drive(4'b0100, 4'd0, 16'd0, 1'b1); tick();
    chk("os_acc_cleared", bus.out_s, 16'd0);
    drive(4'b0100, 4'd0, 16'd0, 1'b0); tick();

    for (int r = 0; r < 8; r++) begin
      rs = 1'($urandom);
      k = $urandom_range(1, 6);
      sum = 0;
      for (int j = 0; j < k; j++) begin
        ra = 4'($urandom); rw = 4'($urandom);
        sum += ref_p(ra, rw, rs);
        drive({rs, 3'b110}, ra, {12'($urandom), rw}, 1'b0); tick();
      end
      drive({rs, 3'b100}, 4'd0, 16'd0, 1'b1); tick();
      chk($sformatf("os_rand%0d", r), bus.out_s, 16'(sum));
      drive({rs, 3'b100}, 4'd0, 16'd0, 1'b0); tick();
    end

    // Mode toggled mid-accumulation discards partial sum
    drive(4'b0110, 4'd2, 16'd3, 1'b0); tick();
    drive(4'b0110, 4'd4, 16'd2, 1'b0); tick();
    drive(4'b0000, 4'd0, 16'd0, 1'b0); tick();
    drive(4'b0110, 4'd1, 16'd5, 1'b0); tick();
    drive(4'b0100, 4'd0, 16'd0, 1'b1); tick();
    chk("os_toggle_clears", bus.out_s, 16'd5);
    drive(4'b0100, 4'd0, 16'd0, 1'b0); tick();

    // Async reset between edges while forwarding
    drive(4'b0110, 4'd2, 16'd3, 1'b0); tick();
    drive(4'b0100, 4'd0, 16'd0, 1'b1); tick();
    drive(4'b0100, 4'd0, 16'h33, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_out_s", bus.out_s, 16'd0);
    chk("async_out_e", {12'd0, bus.out_e}, 16'd0);
    chk("async_inst_e", {12'd0, bus.inst_e}, 16'd0);
    chk("async_flush_out", {15'd0, bus.flush_out}, 16'd0);
    #1 reset = 1'b0;
    drive(4'b0001, 4'd6, 16'd0, 1'b0); tick();
    chk("post_reset_out_e", {12'd0, bus.out_e}, 16'd6);
    drive(4'b0010, 4'd1, 16'd0, 1'b0); tick();
    chk("post_reset_load", bus.out_s, 16'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_tile_reconfig.md
Name: mac_tile_reconfig

Overview:
Parametrised successor to the systolic PE, for the reconfigurable array. It supports weight-stationary (WS) and output-stationary (OS) dataflows, plus a SIMD precision mode that splits each operand into two half-width lanes. OS mode gains an explicit flush FSM and a daisy-chained flush output, so a column drains without external sequencing. Tiles abut west-to-east (activations, instructions, flush) and north-to-south (psums/weights).

Parameters:
bw, 4, activation/weight width; must be even (SIMD lanes are bw/2)
psum_bw, 16, partial-sum/accumulator width; psum_bw >= 2*bw+2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_w  in  bw  activation (and WS kernel value) from west
out_e  out  bw  registered activation to east
in_n  in  psum_bw  psum from north (WS/OS flush); OS weight in [bw-1:0]
out_s  out  psum_bw  psum / forwarded weight to south
inst_w  in  4  [0] kernel load, [1] execute, [2] mode (0 WS, 1 OS), [3] SIMD (0 full bw, 1 two bw/2 lanes)
inst_e  out  4  registered instruction to east
flush_in  in  1  OS flush request from west
flush_out  out  1  flush_in delayed one cycle

Behaviour:
- Reset (async, effective immediately): a_q, b_q, c_q, acc, out_s_q, inst_q, flush_out = 0; load_ready = 1; FSM = RUN; out_s = 0; out_e = 0; inst_e = 0.
- Product P(a,w): activations unsigned, weights two's-complement signed.
  - SIMD = 0: P = a*w.
  - SIMD = 1: P = a_hi*w_hi + a_lo*w_lo (lanes are bw/2 bits).
  - P is sign-extended to psum_bw. All sums wrap modulo 2^psum_bw; no saturation.
- mode_q, simd_q: registered copies of inst_w[2] and inst_w[3]. A change in inst_w[2] forces load_ready = 1, acc = 0, FSM = RUN on the same edge.
- inst_e: inst_q <= inst_w each cycle, except in WS mode, where inst_q[0] <= inst_w[0] only while load_ready = 0 (otherwise 0).
- WS mode:
  - If inst_w[0] or inst_w[1]: a_q <= in_w.
  - If inst_w[0] and load_ready: b_q <= in_w, load_ready <= 0. The first kernel value is captured; later values pass east.
  - Re-arm: load_ready <= 1 on the falling edge of inst_w[1] (previous value 1, current value 0).
  - If inst_w[1]: c_q <= in_n.
  - out_s = c_q + P(a_q, b_q), combinational from registers. Latency from in_w/in_n to out_s: 1 cycle.
- OS mode, FSM {RUN, FWD}:
  - RUN, flush_in = 0, inst_w[1] = 1: a_q <= in_w; b_q <= in_n[bw-1:0]; exec_q <= 1.
  - RUN, otherwise: exec_q <= 0.
  - If exec_q (and not flushing): acc <= acc + P(a_q, b_q).
  - out_s_q <= zero-extended b_q (weight passes south, 1-cycle delay).
  - RUN, flush_in = 1: out_s_q <= acc + (exec_q ? P(a_q,b_q) : 0), so the pending product is included. Then acc <= 0, exec_q <= 0, go to FWD. Execute is ignored in any cycle with flush_in = 1 (flush wins).
  - FWD, flush_in = 1: out_s_q <= in_n (forward upstream psums).
  - FWD, flush_in = 0: go to RUN; out_s_q <= zero-extended b_q.
  - out_s = out_s_q in OS mode; 1 register from in_n to out_s.
- out_e = a_q in both modes. flush_out <= flush_in in all modes; the FSM ignores flush_in in WS mode.
- The output mux selects on mode_q, never on raw inst_w, so there is no combinational path from inst_w to out_s.
- Reset mid-flush or mid-load: all state returns to the reset values above; a partial accumulation is discarded.

Test Plan:
- WS load: inst_w=4'b0001, in_w=3 then 5 → b_q=3; inst_e[0]=0 then 1; out_e=3 then 5, each one cycle after in_w.
- WS execute: b_q=3, in_w=5, in_n=10, inst_w=4'b0010 → out_s=25 next cycle. With b_q=4'b1110 (−2), in_w=7, in_n=0 → out_s=16'hFFF2. Drop inst_w[1], then inst_w=4'b0001, in_w=6 → b_q=6 (re-armed).
- OS accumulate+flush: inst_w=4'b0110, (in_w, in_n[3:0]) = (2,3), (4,4'hF), (1,5). Then flush_in=1 for 3 cycles with in_n=100, 200 → out_s = 7, 100, 200; acc = 0 afterwards; flush_out mirrors flush_in one cycle later.
- SIMD WS: inst_w[3]=1, b_q=4'b0111 (hi=+1, lo=−1), in_w=4'b1011 (hi=2, lo=3), in_n=5 → out_s=4.
- Async reset asserted between clock edges during FWD → out_s, out_e, inst_e, flush_out = 0 immediately; after release, the FSM is RUN and a kernel load is accepted.
- Wrap: WS, b_q=1, in_w=1, in_n=16'h7FFF → out_s=16'h8000. OS mode toggled mid-accumulation → acc cleared; the next flush emits only new products.
